decompressor3_stream: RTL and testbench
=======================================

DECOMPRESSOR3_STREAM -- requirements
Module: decompressor3_stream

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter N, default 3, giving the number of elements per packed vector; legal range is N >= 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it SHALL be asynchronous and active-high.
REQ-005 The block SHALL have port in_vec, input, N*W, the packed vector; element k SHALL occupy bits [k*W+W-1 : k*W].
REQ-006 The block SHALL have port in_valid, input, 1, asserted when in_vec is valid.
REQ-007 The block SHALL have port in_ready, output, 1, asserted when the block accepts a vector.
REQ-008 The block SHALL have port out_data, output, W, the current element.
REQ-009 The block SHALL have port out_idx, output, $clog2(N), the index of the current element.
REQ-010 The block SHALL have port out_last, output, 1, asserted with the element at index N-1.
REQ-011 The block SHALL have port out_valid, output, 1, asserted when out_data is valid.
REQ-012 The block SHALL have port out_ready, input, 1, the downstream accept signal.

Function
REQ-013 An input transfer SHALL occur in a cycle where in_valid and in_ready are both 1; an output transfer SHALL occur in a cycle where out_valid and out_ready are both 1.
REQ-014 The block SHALL implement a two-state FSM with states IDLE and SEND.
REQ-015 In IDLE: in_ready=1 and out_valid=0; on an input transfer, the block SHALL latch in_vec into a holding register, set idx=0, and move to SEND.
REQ-016 In SEND: out_valid=1, out_data=holding[idx], out_idx=idx, and out_last=(idx==N-1).
REQ-017 In SEND, an output transfer with idx<N-1 SHALL increment idx by 1.
REQ-018 In SEND, an output transfer with idx==N-1 and no simultaneous input transfer SHALL move the FSM to IDLE with idx=0.
REQ-019 in_ready SHALL equal IDLE OR (SEND AND out_last AND out_ready); this combinational path from out_ready is intended.
REQ-020 An input transfer coincident with the last output transfer SHALL latch the new vector, set idx=0, and keep the FSM in SEND, giving back-to-back vectors with no bubble.
REQ-021 Latency SHALL be one cycle from input transfer to the first out_valid; steady-state throughput SHALL be one element per cycle when out_ready is held at 1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-023 When out_valid=0, out_data SHALL be 0, and out_idx and out_last SHALL be 0.
REQ-024 The holding register SHALL change only on an input transfer; changes to in_vec at any other time SHALL have no effect.

Reset
REQ-025 When rst is asserted, the block SHALL immediately force: FSM=IDLE, idx=0, holding register=0, out_valid=0, out_data=0, out_last=0.
REQ-026 While rst is high, in_ready SHALL be 0 and no transfer SHALL occur.
REQ-027 Asserting rst mid-vector SHALL discard the remaining elements; after rst is released, the first accepted vector SHALL start at index 0.

Structure
REQ-028 The FSM state typedef (IDLE, SEND) and the default element width constant SHALL be placed in the project shared package.
REQ-029 The block SHALL be a single module with no sub-modules; element selection SHALL be an indexed part-select of the holding register.

Verification
REQ-030 Scenario 1 (single vector): W=8, N=3, in_vec=0x332211, out_ready=1 -> out_data 0x11, 0x22, 0x33 on three consecutive cycles; out_idx 0,1,2; out_last only on 0x33.
REQ-031 Scenario 2 (back-to-back): send 0x332211 then 0x665544 with in_valid held -> six consecutive output beats with no gap; the second vector is accepted in the same cycle as the beat carrying 0x33.
REQ-032 Scenario 3 (backpressure): out_ready=0 for 4 cycles at idx=1 -> out_data holds 0x22 and out_idx holds 1; in_ready=0 throughout; the sequence resumes correctly when out_ready returns to 1.
REQ-033 Scenario 4 (mid-vector reset): assert rst after the 0x11 beat -> out_valid=0 asynchronously; the next vector 0xCCBBAA yields 0xAA first.
REQ-034 Scenario 5 (input stability): change in_vec while in SEND with in_valid=0 -> outputs are unaffected.
REQ-035 Scenario 6 (random): randomized in_valid/out_ready for 1000 vectors -> a scoreboard confirms every element is delivered in order, with none lost or duplicated.

Source files
------------

// File: rtl/decompressor3_stream_pkg.sv
// decompressor3_stream_pkg: shared FSM state type and default element width
package decompressor3_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/decompressor3_stream.sv
// decompressor3_stream: unpacks an N-element vector into a stream of W-bit elements
module decompressor3_stream
    import decompressor3_stream_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int IW = $clog2(N);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [N*W-1:0]  holding;
    logic            at_last;
    logic            in_fire;

    // Output view of the registered state; zeroed whenever no element is offered
    always_comb begin
        at_last   = (idx == IW'(N - 1));
        out_valid = (state == SEND);
        out_data  = out_valid ? holding[int'(idx) * W +: W] : '0;
        out_idx   = out_valid ? idx : '0;
        out_last  = out_valid && at_last;
        in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
        in_fire   = in_valid && in_ready;
    end

    // FSM: load a vector, then walk the index one accepted element at a time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            holding <= '0;
        end else if (in_fire) begin
            state   <= SEND;
            idx     <= '0;
            holding <= in_vec;
        end else if (state == SEND && out_ready) begin
            if (at_last) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decompressor3_stream.sv
// tb_decompressor3_stream: directed and randomized checks of the vector-to-stream unpacker
module tb_decompressor3_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_vec = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    decompressor3_stream #(.W(8), .N(3)) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 2'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h i=%0d l=%b rdy=%b, want all 0", out_valid, out_data, out_idx, out_last, in_ready);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        logic [7:0] e [3];
        e = '{8'h11, 8'h22, 8'h33};
        in_vec = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[i] || out_idx !== 2'(i) || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL single beat%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                         i, out_valid, out_data, out_idx, out_last, e[i], i, (i == 2));
            end
            step();
            #1;
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: got v=%b d=%h rdy=%b, want v=0 d=00 rdy=1", out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [6];
        e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        in_vec = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_vec = 24'h665544;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[i] || out_idx !== 2'(i % 3) || in_ready !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL b2b beat%0d: got v=%b d=%h i=%0d rdy=%b, want v=1 d=%h i=%0d rdy=%b",
                         i, out_valid, out_data, out_idx, in_ready, e[i], i % 3, (i % 3 == 2));
            end
            step();
            if (i == 2) in_valid = 1'b0;
            #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_vec = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_data !== 8'h11 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL bp_first: got d=%h i=%0d, want 11 0", out_data, out_idx);
        end
        step();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h22 || out_idx !== 2'd1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h i=%0d l=%b rdy=%b, want v=1 d=22 i=1 l=0 rdy=0",
                         i, out_valid, out_data, out_idx, out_last, in_ready);
            end
            step();
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_data !== 8'h22 || out_idx !== 2'd1) begin
            errors++;
            $display("FAIL bp_resume: got d=%h i=%0d, want 22 1", out_data, out_idx);
        end
        step();
        #1;
        checks++;
        if (out_data !== 8'h33 || out_idx !== 2'd2 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: got d=%h i=%0d l=%b, want 33 2 1", out_data, out_idx, out_last);
        end
        step();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e [3];
        e = '{8'hAA, 8'hBB, 8'hCC};
        in_vec = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h l=%b rdy=%b, want all 0", out_valid, out_data, out_last, in_ready);
        end
        in_vec = 24'hCCBBAA; in_valid = 1'b1;
        step();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b rdy=%b, want 0 0", out_valid, in_ready);
        end
        rst = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[i] || out_idx !== 2'(i)) begin
                errors++;
                $display("FAIL post_reset beat%0d: got v=%b d=%h i=%0d, want v=1 d=%h i=%0d",
                         i, out_valid, out_data, out_idx, e[i], i);
            end
            step();
            #1;
        end
    endtask

    task automatic test_stability();
        in_vec = 24'h332211; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_vec = 24'h998877;
        #1;
        checks++;
        if (out_data !== 8'h11 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL stable_first: got d=%h i=%0d, want 11 0", out_data, out_idx);
        end
        out_ready = 1'b1;
        step();
        in_vec = 24'h000000;
        #1;
        checks++;
        if (out_data !== 8'h22) begin
            errors++;
            $display("FAIL stable_mid: got d=%h, want 22", out_data);
        end
        step();
        #1;
        checks++;
        if (out_data !== 8'h33 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL stable_last: got d=%h l=%b, want 33 1", out_data, out_last);
        end
        step();
        #1;
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        int sent = 0;
        int got = 0;
        int exp_idx = 0;
        int cycles = 0;
        logic [7:0] e;
        while ((sent < 1000 || q.size() != 0) && cycles < 30000) begin
            @(posedge clk);
            #1;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_vec = 24'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                e = (q.size() != 0) ? q.pop_front() : 8'hXX;
                checks++;
                if (out_data !== e || out_idx !== 2'(exp_idx) || out_last !== (exp_idx == 2)) begin
                    errors++;
                    $display("FAIL rand beat%0d: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b",
                             got, out_data, out_idx, out_last, e, exp_idx, (exp_idx == 2));
                end
                got++;
                exp_idx = (exp_idx == 2) ? 0 : exp_idx + 1;
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 3; k++) q.push_back(in_vec[k*8 +: 8]);
                sent++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 3000 || sent != 1000) begin
            errors++;
            $display("FAIL rand_total: got %0d beats from %0d vectors, want 3000 from 1000", got, sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_stability();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
